// File: rtl/audio_frame_buffer.sv
// audio_frame_buffer: ping-pong frame store between the I2S receiver and the
// FFT loader. Samples are truncated to OUT_BITS and written into one bank
// while the other bank is held for random-access reading. The writer never
// stalls; a frame completed while the consumer still holds the previous one
// is dropped and counted.
module audio_frame_buffer #(
    parameter  int DATA_BITS = 24,
    parameter  int OUT_BITS  = 16,
    parameter  int FRAME_LEN = 256,
    localparam int ADDR_BITS = $clog2(FRAME_LEN)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] in_data,
    input  logic                 in_valid,
    output logic                 frame_ready,
    output logic [7:0]           frame_seq,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic [OUT_BITS-1:0]  rd_data,
    input  logic                 frame_release,
    output logic                 overrun,
    output logic [7:0]           overrun_cnt
);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_READY = 1'b1
    } state_t;

    // Two banks addressed {bank, index}; one write port, one read port.
    logic [OUT_BITS-1:0] mem [2*FRAME_LEN];

    state_t               state_q, state_d;
    logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic                 wr_bank_q, wr_bank_d;
    logic                 rd_bank_q, rd_bank_d;
    logic [7:0]           seq_q, seq_d;
    logic                 ovr_q, ovr_d;
    logic [7:0]           ovr_cnt_q, ovr_cnt_d;
    logic [OUT_BITS-1:0]  rd_data_q;

    logic                 fc;       // last sample of a frame is being written
    logic                 publish;  // completed frame becomes the held frame
    logic                 drop;     // completed frame is discarded
    logic [OUT_BITS-1:0]  wr_sample;

    // Low-order sample bits are intentionally discarded by truncation.
    logic unused_in_bits;
    assign unused_in_bits = ^in_data;

    // Keep the top OUT_BITS: arithmetic shift down, sign preserved, no rounding.
    assign wr_sample = in_data[DATA_BITS-1 -: OUT_BITS];

    assign fc      = in_valid && (&wr_ptr_q);
    // A release in the same cycle frees the held bank, so it wins over a drop.
    assign publish = fc && ((state_q == S_EMPTY) || frame_release);
    assign drop    = fc && (state_q == S_READY) && !frame_release;

    // State register: read FSM plus the write-side bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_EMPTY;
            wr_ptr_q  <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b1;
            seq_q     <= 8'd0;
            ovr_q     <= 1'b0;
            ovr_cnt_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            seq_q     <= seq_d;
            ovr_q     <= ovr_d;
            ovr_cnt_q <= ovr_cnt_d;
        end
    end

    // Next-state logic: FSM transitions, bank swap on publish, drop accounting.
    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        seq_d     = seq_q;
        ovr_d     = 1'b0;
        ovr_cnt_d = ovr_cnt_q;

        if (in_valid) begin
            wr_ptr_d = wr_ptr_q + ADDR_BITS'(1);
        end

        case (state_q)
            S_EMPTY: begin
                if (fc) state_d = S_READY;
            end
            S_READY: begin
                // A coincident FC keeps us READY (publish or drop).
                if (frame_release && !fc) state_d = S_EMPTY;
            end
            default: state_d = S_EMPTY;
        endcase

        if (publish) begin
            rd_bank_d = wr_bank_q;
            wr_bank_d = ~wr_bank_q;
            seq_d     = seq_q + 8'd1;
        end

        if (drop) begin
            // The write bank is reused, so the dropped frame is simply overwritten.
            ovr_d = 1'b1;
            if (ovr_cnt_q != 8'hFF) ovr_cnt_d = ovr_cnt_q + 8'd1;
        end
    end

    // Output logic: Moore outputs straight from registers.
    always_comb begin
        frame_ready = (state_q == S_READY);
        frame_seq   = seq_q;
        overrun     = ovr_q;
        overrun_cnt = ovr_cnt_q;
        rd_data     = rd_data_q;
    end

    // RAM write port; the held bank is never the write bank, so reads stay stable.
    always_ff @(posedge clk) begin
        if (rst_n && in_valid) begin
            mem[{wr_bank_q, wr_ptr_q}] <= wr_sample;
        end
    end

    // RAM read port with registered output, one cycle of latency.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem[{rd_bank_q, rd_addr}];
        end
    end

endmodule
